// File: rtl/ram_satir_yanitlayici.sv
// rtl/ram_satir_yanitlayici.sv - line-organised RAM responder for the cache-line memory interface
//
// Accepts one line read/write request at a time and returns a single response
// after GECIKME extra wait cycles.
//
// Ports:
//   clk_i            clock
//   rst_i            asynchronous reset, active-high
//   istek_gecerli_i  request valid
//   istek_hazir_o    request ready (high only while idle)
//   istek_adres_i    byte address; bits below the line size are ignored
//   istek_yaz_i      1 = write, 0 = read
//   istek_veri_i     write line, word 0 in [31:0]
//   istek_maske_i    byte enables, bit k -> byte k of the line
//   yanit_gecerli_o  response valid
//   yanit_hazir_i    response ready
//   yanit_veri_o     read line (zero for writes and range errors)
//   yanit_hata_o     address outside [TABAN_ADRES, SON_ADRES)

module ram_satir_yanitlayici #(
  parameter int          SATIR_SAYISI = 512,
  parameter int          SATIR_SOZCUK = 4,
  parameter int          GECIKME      = 0,
  parameter logic [31:0] TABAN_ADRES  = 32'h8000_0000,
  parameter logic [31:0] SON_ADRES    = 32'h8100_0000
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      istek_gecerli_i,
  output logic                      istek_hazir_o,
  input  logic [31:0]               istek_adres_i,
  input  logic                      istek_yaz_i,
  input  logic [32*SATIR_SOZCUK-1:0] istek_veri_i,
  input  logic [4*SATIR_SOZCUK-1:0]  istek_maske_i,
  output logic                      yanit_gecerli_o,
  input  logic                      yanit_hazir_i,
  output logic [32*SATIR_SOZCUK-1:0] yanit_veri_o,
  output logic                      yanit_hata_o
);

  localparam int SATIR_BIT = 32 * SATIR_SOZCUK;
  localparam int BAYT_SAY  = 4 * SATIR_SOZCUK;
  localparam int OFS       = $clog2(BAYT_SAY);
  localparam int IDX_W     = (SATIR_SAYISI > 1) ? $clog2(SATIR_SAYISI) : 1;
  localparam int SAYAC_W   = (GECIKME > 1) ? $clog2(GECIKME) : 1;

  typedef enum logic [1:0] {BOSTA, BEKLE, YANIT} durum_t;

  durum_t durum, sonraki;

  logic [SATIR_BIT-1:0] bellek [SATIR_SAYISI];

  logic [SAYAC_W-1:0]   sayac;
  logic [31:0]          l_adres;
  logic                 l_yaz;
  logic [SATIR_BIT-1:0] l_veri;
  logic [BAYT_SAY-1:0]  l_maske;

  logic                 kabul;
  logic                 erisim;

  // The array is accessed on the edge that enters YANIT. With zero latency
  // that is the acceptance edge itself, so the request is taken straight
  // from the inputs; otherwise from the copy latched at acceptance.
  logic [31:0]          e_adres;
  logic                 e_yaz;
  logic [SATIR_BIT-1:0] e_veri;
  logic [BAYT_SAY-1:0]  e_maske;
  logic                 e_hata;
  logic [IDX_W-1:0]     e_index;

  assign e_adres = (durum == BOSTA) ? istek_adres_i : l_adres;
  assign e_yaz   = (durum == BOSTA) ? istek_yaz_i   : l_yaz;
  assign e_veri  = (durum == BOSTA) ? istek_veri_i  : l_veri;
  assign e_maske = (durum == BOSTA) ? istek_maske_i : l_maske;
  assign e_hata  = (e_adres < TABAN_ADRES) || (e_adres >= SON_ADRES);
  // Addresses past the array simply alias onto lower lines.
  assign e_index = IDX_W'((e_adres - TABAN_ADRES) >> OFS);

  assign yanit_gecerli_o = (durum == YANIT);

  always_comb begin
    sonraki       = durum;
    istek_hazir_o = 1'b0;
    kabul         = 1'b0;
    erisim        = 1'b0;
    case (durum)
      BOSTA: begin
        istek_hazir_o = 1'b1;
        if (istek_gecerli_i) begin
          kabul = 1'b1;
          if (GECIKME == 0) begin
            sonraki = YANIT;
            erisim  = 1'b1;
          end else begin
            sonraki = BEKLE;
          end
        end
      end
      BEKLE: begin
        if (sayac == '0) begin
          sonraki = YANIT;
          erisim  = 1'b1;
        end
      end
      YANIT: begin
        if (yanit_hazir_i) sonraki = BOSTA;
      end
      default: sonraki = BOSTA;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum        <= BOSTA;
      sayac        <= '0;
      l_adres      <= '0;
      l_yaz        <= 1'b0;
      l_veri       <= '0;
      l_maske      <= '0;
      yanit_veri_o <= '0;
      yanit_hata_o <= 1'b0;
    end else begin
      durum <= sonraki;
      if (kabul) begin
        l_adres <= istek_adres_i;
        l_yaz   <= istek_yaz_i;
        l_veri  <= istek_veri_i;
        l_maske <= istek_maske_i;
        if (GECIKME > 0) sayac <= SAYAC_W'(GECIKME - 1);
      end else if ((durum == BEKLE) && (sayac != '0)) begin
        sayac <= sayac - 1'b1;
      end
      if (erisim) begin
        yanit_hata_o <= e_hata;
        yanit_veri_o <= (e_hata || e_yaz) ? '0 : bellek[e_index];
      end else if ((durum == YANIT) && yanit_hazir_i) begin
        yanit_hata_o <= 1'b0;
        yanit_veri_o <= '0;
      end
    end
  end

  // Contents survive reset; a reset during BEKLE moves the FSM to BOSTA
  // before the access edge, so the pending write is dropped.
  always_ff @(posedge clk_i) begin
    if (erisim && e_yaz && !e_hata) begin
      for (int k = 0; k < BAYT_SAY; k++) begin
        if (e_maske[k]) bellek[e_index][8*k +: 8] <= e_veri[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ram_satir_yanitlayici.sv
// tb/tb_ram_satir_yanitlayici.sv - randomized self-checking bench for ram_satir_yanitlayici

module tb_ram_satir_yanitlayici;

  localparam logic [31:0] TABAN = 32'h8000_0000;
  localparam logic [31:0] SON   = 32'h8100_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [31:0]  adres;
  logic         yaz;
  logic [127:0] veri;
  logic [15:0]  maske;
  logic         ig0, ig1, ih0, ih1, yg0, yg1, yh0, yh1, ye0, ye1;
  logic [127:0] yv0, yv1;

  int checks = 0;
  int errors = 0;

  logic [127:0] model [2][512];
  logic [127:0] son_veri;
  logic         son_hata;

  ram_satir_yanitlayici #(.GECIKME(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst),
    .istek_gecerli_i(ig0), .istek_hazir_o(ih0), .istek_adres_i(adres),
    .istek_yaz_i(yaz), .istek_veri_i(veri), .istek_maske_i(maske),
    .yanit_gecerli_o(yg0), .yanit_hazir_i(yh0), .yanit_veri_o(yv0), .yanit_hata_o(ye0)
  );

  ram_satir_yanitlayici #(.GECIKME(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst),
    .istek_gecerli_i(ig1), .istek_hazir_o(ih1), .istek_adres_i(adres),
    .istek_yaz_i(yaz), .istek_veri_i(veri), .istek_maske_i(maske),
    .yanit_gecerli_o(yg1), .yanit_hazir_i(yh1), .yanit_veri_o(yv1), .yanit_hata_o(ye1)
  );

  task automatic kontrol(input string etiket, input logic [127:0] gozlenen, input logic [127:0] beklenen);
    checks++;
    if (gozlenen !== beklenen) begin
      errors++;
      $display("FAIL %s: observed %h expected %h", etiket, gozlenen, beklenen);
    end
  endtask

  function automatic logic aralik_disi(input logic [31:0] a);
    return (a < TABAN) || (a >= SON);
  endfunction

  function automatic int satir(input logic [31:0] a);
    logic [31:0] fark;
    fark = a - TABAN;
    return int'((fark / 16) % 512);
  endfunction

  function automatic logic hz(input int s);
    return (s == 0) ? ih0 : ih1;
  endfunction

  function automatic logic ygec(input int s);
    return (s == 0) ? yg0 : yg1;
  endfunction

  function automatic logic [127:0] yveri(input int s);
    return (s == 0) ? yv0 : yv1;
  endfunction

  function automatic logic yhata(input int s);
    return (s == 0) ? ye0 : ye1;
  endfunction

  function automatic logic [127:0] rastgele_satir();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One full request/response transaction against instance s (0: no wait, 1: three wait cycles).
  task automatic istek_yap(input int s, input logic [31:0] a, input logic y,
                           input logic [127:0] d, input logic [15:0] m, input int ekstra);
    int n;
    logic [127:0] bek;
    logic [127:0] yeni;
    logic bh;
    bh  = aralik_disi(a);
    bek = (bh || y) ? 128'h0 : model[s][satir(a)];
    if (!bh && y) begin
      yeni = model[s][satir(a)];
      for (int k = 0; k < 16; k++) if (m[k]) yeni[8*k +: 8] = d[8*k +: 8];
      model[s][satir(a)] = yeni;
    end
    @(negedge clk);
    adres = a; yaz = y; veri = d; maske = m;
    if (s == 0) ig0 = 1'b1; else ig1 = 1'b1;
    kontrol("istek_hazir_bosta", hz(s), 1);
    @(posedge clk); #1;
    ig0 = 1'b0; ig1 = 1'b0;
    adres = $urandom; yaz = 1'($urandom); veri = rastgele_satir(); maske = 16'($urandom);
    n = 0;
    while (!ygec(s) && n < 40) begin
      kontrol("istek_hazir_bekle", hz(s), 0);
      @(posedge clk); #1;
      n++;
    end
    kontrol("yanit_gecerli", ygec(s), 1);
    kontrol("gecikme", n, (s == 0) ? 0 : 3);
    kontrol("istek_hazir_yanit", hz(s), 0);
    son_veri = yveri(s);
    son_hata = yhata(s);
    kontrol("yanit_veri", son_veri, bek);
    kontrol("yanit_hata", son_hata, bh);
    repeat (ekstra) begin
      @(posedge clk); #1;
      kontrol("tutma_gecerli", ygec(s), 1);
      kontrol("tutma_veri", yveri(s), bek);
      kontrol("tutma_hata", yhata(s), bh);
      kontrol("tutma_hazir", hz(s), 0);
    end
    @(negedge clk);
    if (s == 0) yh0 = 1'b1; else yh1 = 1'b1;
    @(posedge clk); #1;
    yh0 = 1'b0; yh1 = 1'b0;
    kontrol("sonra_gecerli", ygec(s), 0);
    kontrol("sonra_veri", yveri(s), 0);
    kontrol("sonra_hata", yhata(s), 0);
    kontrol("sonra_hazir", hz(s), 1);
  endtask

  int havuz [6] = '{0, 1, 2, 5, 37, 511};
  logic [31:0] disari [4] = '{32'h7FFF_FFF0, 32'h8100_0000, 32'hFFFF_FFF0, 32'h0000_0000};

  initial begin
    logic [127:0] x, yv, t1;
    logic [31:0] a;
    logic [15:0] m;
    int s, r;

    rst = 1'b1; ig0 = 0; ig1 = 0; yh0 = 0; yh1 = 0;
    adres = '0; yaz = 0; veri = '0; maske = '0;
    repeat (3) @(posedge clk);
    #1;
    kontrol("rst_gecerli0", yg0, 0);
    kontrol("rst_gecerli3", yg1, 0);
    kontrol("rst_veri0", yv0, 0);
    kontrol("rst_hata3", ye1, 0);
    @(negedge clk); rst = 1'b0;
    #1;
    kontrol("rst_sonra_hazir0", ih0, 1);
    kontrol("rst_sonra_hazir3", ih1, 1);

    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 6; j++)
        istek_yap(i, TABAN + 32'(havuz[j]) * 16, 1'b1, rastgele_satir(), 16'hFFFF, 0);

    // Full-line write then read, zero latency.
    t1 = {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};
    istek_yap(0, 32'h8000_0010, 1'b1, t1, 16'hFFFF, 0);
    istek_yap(0, 32'h8000_0010, 1'b0, '0, '0, 0);
    kontrol("t1_okuma", son_veri, t1);

    // Partial write onto a zero line.
    istek_yap(0, 32'h8000_0020, 1'b1, '0, 16'hFFFF, 0);
    istek_yap(0, 32'h8000_0020, 1'b1, {128{1'b1}}, 16'h00F0, 0);
    istek_yap(0, 32'h8000_0020, 1'b0, '0, '0, 0);
    kontrol("t2_kismi", son_veri, 128'h0000_0000_0000_0000_FFFF_FFFF_0000_0000);

    // Out-of-range writes alias onto lines 511 and 0 but must not touch them.
    x  = model[0][511];
    yv = model[0][0];
    istek_yap(0, 32'h7FFF_FFF0, 1'b1, rastgele_satir(), 16'hFFFF, 0);
    istek_yap(0, 32'h8100_0000, 1'b1, rastgele_satir(), 16'hFFFF, 1);
    istek_yap(0, 32'h8000_1FF0, 1'b0, '0, '0, 0);
    kontrol("t3_satir511", son_veri, x);
    istek_yap(0, 32'h8000_0000, 1'b0, '0, '0, 0);
    kontrol("t3_satir0", son_veri, yv);

    // Index wrap: line 512 aliases line 0.
    x  = rastgele_satir();
    yv = rastgele_satir();
    istek_yap(0, 32'h8000_0000, 1'b1, x, 16'hFFFF, 0);
    istek_yap(0, 32'h8000_0000 + 512 * 16, 1'b1, yv, 16'hFFFF, 0);
    istek_yap(0, 32'h8000_0000, 1'b0, '0, '0, 0);
    kontrol("t5_ilk", son_veri, yv);
    istek_yap(0, 32'h8000_0000 + 512 * 16, 1'b0, '0, '0, 0);
    kontrol("t5_ikinci", son_veri, yv);

    // Three-cycle latency with the response held for two extra cycles.
    istek_yap(1, 32'h8000_0050, 1'b0, '0, '0, 2);

    // Reset during the wait phase of a write aborts it.
    @(negedge clk);
    adres = 32'h8000_0050; yaz = 1'b1; veri = rastgele_satir(); maske = 16'hFFFF; ig1 = 1'b1;
    @(posedge clk); #1;
    ig1 = 1'b0;
    kontrol("t6_bekle_hazir", ih1, 0);
    #2 rst = 1'b1;
    #1;
    kontrol("t6_rst_hazir", ih1, 1);
    kontrol("t6_rst_gecerli", yg1, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      kontrol("t6_yanit_yok", yg1, 0);
    end
    istek_yap(1, 32'h8000_0050, 1'b0, '0, '0, 0);
    istek_yap(1, 32'h8000_0250, 1'b1, rastgele_satir(), 16'h0F0F, 0);
    istek_yap(1, 32'h8000_0250, 1'b0, '0, '0, 1);

    for (int i = 0; i < 80; i++) begin
      s = $urandom_range(0, 1);
      r = $urandom_range(0, 9);
      if (r < 6)      a = TABAN + 32'(havuz[$urandom_range(0, 5)]) * 16 + 32'($urandom_range(0, 15));
      else if (r < 8) a = TABAN + 32'(havuz[$urandom_range(0, 5)] + 512) * 16;
      else            a = disari[$urandom_range(0, 3)];
      r = $urandom_range(0, 3);
      m = (r == 0) ? 16'h0000 : (r == 1) ? 16'hFFFF : 16'($urandom);
      istek_yap(s, a, 1'($urandom), rastgele_satir(), m, $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL zaman_asimi: observed running expected finished");
    $fatal(1);
  end

endmodule
